// File: rtl/serdes_rx_link_align.sv
// serdes_rx_link_align: receive-side link front end for the 8b/10b user-data path.
// Finds commas in any byte lane and locks onto them after a run of hits. It then
// waits for the RX sync pattern to bring the link up and captures the config word
// that follows the TX sync pattern. If commas stop, it drops back to hunting.
// Optional feature macro: SERDES_RX_REALIGN_CNT_EN enables the realignment counter.
module serdes_rx_link_align #(
  parameter int          BYTES        = 2,
  parameter logic [7:0]  COMMA        = 8'hBC,
  parameter int          LOCK_CNT     = 2,
  parameter int          LOSS_TIMEOUT = 1024,
  parameter logic [63:0] P_RX_SYNC    = 64'hf1ba_84ff_aacd_f355,
  parameter logic [63:0] P_TX_SYNC    = 64'hf1ba_84ff_aacd_2420,
  localparam int         W            = 8 * BYTES
) (
  input  logic             I_serdes_clk,
  input  logic             I_rst_n,
  input  logic [W-1:0]     I_serdes_data,
  input  logic [BYTES-1:0] I_data_is_k,
  output logic [W-1:0]     O_user_data,
  output logic             O_data_ena,
  output logic [W-1:0]     O_config_data,
  output logic             O_config_ena,
  output logic [1:0]       O_link_state,
  output logic             O_rx_link,
  output logic             O_tx_link,
  output logic [15:0]      O_realign_cnt
);

  localparam int OW = $clog2(BYTES);

  typedef enum logic [1:0] {HUNT = 2'd0, ALIGNED = 2'd1, LINKED = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       r_data, r1_data;
  logic [BYTES-1:0]   r_k, r1_k;
  logic               hit;
  logic [OW-1:0]      hit_off, offset, cand_off;
  logic [3:0]         lock_cnt, cnt_next;
  logic [15:0]        loss_tmr, tmr_inc;
  logic [63:0]        sync_sr;
  logic               cfg_armed;
  logic [2*W-9:0]     cat_data;
  logic [2*BYTES-2:0] cat_k;
  logic [W-1:0]       algn_data;
  logic [BYTES-1:0]   algn_k;
  logic               good_hit, bad_hit, timeout, lock_now, lock, enter_hunt, tx_match;

  // Two-stage input pipeline: current word and the one before it.
  always_ff @(posedge I_serdes_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_data  <= '0;
      r_k     <= '0;
      r1_data <= '0;
      r1_k    <= '0;
    end else begin
      r_data  <= I_serdes_data;
      r_k     <= I_data_is_k;
      r1_data <= r_data;
      r1_k    <= r_k;
    end
  end

  // Comma search (lowest lane wins) and byte-offset alignment over two words.
  // The top byte of r_data can never land in an aligned word, so it is left out of the concat.
  always_comb begin
    hit     = 1'b0;
    hit_off = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (!hit && r_k[i] && (r_data[8*i +: 8] == COMMA)) begin
        hit     = 1'b1;
        hit_off = OW'(i);
      end
    end
    cat_data  = {r_data[W-9:0], r1_data};
    cat_k     = {r_k[BYTES-2:0], r1_k};
    algn_data = W'(cat_data >> {offset, 3'b000});
    algn_k    = BYTES'(cat_k >> offset);
  end

  // Link state register.
  always_ff @(posedge I_serdes_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= HUNT;
    else          state <= state_nxt;
  end

  // Next-state logic; a HUNT condition overrides an RX sync match in the same cycle.
  always_comb begin
    good_hit  = hit && (hit_off == offset);
    bad_hit   = hit && (hit_off != offset);
    timeout   = !good_hit && ((17'(loss_tmr) + 17'd1) >= 17'(LOSS_TIMEOUT));
    cnt_next  = ((hit_off == cand_off) && (lock_cnt != 4'd0)) ? lock_cnt + 4'd1 : 4'd1;
    lock_now  = hit && (cnt_next == 4'(LOCK_CNT));
    state_nxt = state;
    case (state)
      HUNT:    if (lock_now) state_nxt = ALIGNED;
      ALIGNED: if (bad_hit || timeout) state_nxt = HUNT;
               else if (sync_sr == P_RX_SYNC) state_nxt = LINKED;
      LINKED:  if (bad_hit || timeout) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
    lock       = (state == HUNT) && lock_now;
    enter_hunt = (state != HUNT) && (state_nxt == HUNT);
    tx_match   = (state != HUNT) && (sync_sr == P_TX_SYNC);
    tmr_inc    = (loss_tmr >= 16'(LOSS_TIMEOUT)) ? loss_tmr : loss_tmr + 16'd1;
  end

  // State-derived outputs.
  always_comb begin
    O_link_state = state;
    O_rx_link    = (state == LINKED);
  end

  // Candidate offset tracking while hunting; the locked offset loads on lock.
  always_ff @(posedge I_serdes_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cand_off <= '0;
      lock_cnt <= '0;
      offset   <= '0;
    end else if (state == HUNT) begin
      if (hit) begin
        cand_off <= hit_off;
        lock_cnt <= lock_now ? 4'd0 : cnt_next;
      end
      if (lock_now) offset <= hit_off;
    end else if (enter_hunt) begin
      lock_cnt <= '0;
    end
  end

  // Sync shift register and loss timer.
  always_ff @(posedge I_serdes_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_sr  <= '0;
      loss_tmr <= '0;
    end else begin
      if (enter_hunt)        sync_sr <= '0;
      else if (algn_k == '0) sync_sr <= {sync_sr[63-W:0], algn_data};
      if ((state == HUNT) || enter_hunt || good_hit) loss_tmr <= '0;
      else                                           loss_tmr <= tmr_inc;
    end
  end

  // Config capture. The word aligned in the header-match cycle is already the
  // first word after the header, so the match itself acts as an armed flag.
  always_ff @(posedge I_serdes_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_tx_link     <= 1'b0;
      cfg_armed     <= 1'b0;
      O_config_data <= '0;
      O_config_ena  <= 1'b0;
    end else begin
      O_config_ena <= 1'b0;
      if (enter_hunt) begin
        O_tx_link <= 1'b0;
        cfg_armed <= 1'b0;
      end else if (state != HUNT) begin
        if (tx_match) O_tx_link <= 1'b1;
        if ((cfg_armed || tx_match) && (algn_k == '0)) begin
          O_config_data <= algn_data;
          O_config_ena  <= 1'b1;
          cfg_armed     <= 1'b0;
        end else if (tx_match) begin
          cfg_armed <= 1'b1;
        end
      end
    end
  end

  // Registered user data path.
  always_ff @(posedge I_serdes_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_user_data <= '0;
      O_data_ena  <= 1'b0;
    end else begin
      O_user_data <= algn_data;
      O_data_ena  <= (state == LINKED) && (algn_k == '0);
    end
  end

`ifdef SERDES_RX_REALIGN_CNT_EN
  // Saturating count of HUNT to ALIGNED locks; only reset clears it.
  always_ff @(posedge I_serdes_clk or negedge I_rst_n) begin
    if (!I_rst_n)                              O_realign_cnt <= '0;
    else if (lock && (O_realign_cnt != 16'hFFFF)) O_realign_cnt <= O_realign_cnt + 16'd1;
  end
`else
  assign O_realign_cnt = '0;
`endif

endmodule

// File: tb/tb_serdes_rx_link_align.sv
// Bench for serdes_rx_link_align: a 2-byte instance (short loss timeout) is
// checked against a data scoreboard and fixed-cycle state checks. A 4-byte
// instance checks lock at byte offset 3.
module tb_serdes_rx_link_align;

  localparam int LOSS_T = 32;
  localparam logic [63:0] RX_SYNC = 64'hf1ba_84ff_aacd_f355;
  localparam logic [63:0] TX_SYNC = 64'hf1ba_84ff_aacd_2420;
  localparam logic [15:0] CMA     = 16'hc5bc;
  localparam logic [15:0] FILL    = 16'h1c1c;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_data = '0;
  logic [1:0]  a_k = '0;
  logic [15:0] a_user, a_cfg, a_rcnt;
  logic        a_ena, a_cfg_ena, a_rx, a_tx;
  logic [1:0]  a_state;
  logic [31:0] b_data = '0;
  logic [3:0]  b_k = '0;
  logic [31:0] b_user, b_cfg;
  logic        b_ena, b_cfg_ena, b_rx, b_tx;
  logic [1:0]  b_state;
  logic [15:0] b_rcnt;

  int errors = 0;
  int checks = 0;
  int exp_rcnt = 0;
  logic a_expect = 1'b0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  serdes_rx_link_align #(.BYTES(2), .LOSS_TIMEOUT(LOSS_T)) u_a (
    .I_serdes_clk(clk), .I_rst_n(rst_n), .I_serdes_data(a_data), .I_data_is_k(a_k),
    .O_user_data(a_user), .O_data_ena(a_ena), .O_config_data(a_cfg), .O_config_ena(a_cfg_ena),
    .O_link_state(a_state), .O_rx_link(a_rx), .O_tx_link(a_tx), .O_realign_cnt(a_rcnt));

  serdes_rx_link_align #(.BYTES(4)) u_b (
    .I_serdes_clk(clk), .I_rst_n(rst_n), .I_serdes_data(b_data), .I_data_is_k(b_k),
    .O_user_data(b_user), .O_data_ena(b_ena), .O_config_data(b_cfg), .O_config_ena(b_cfg_ena),
    .O_link_state(b_state), .O_rx_link(b_rx), .O_tx_link(b_tx), .O_realign_cnt(b_rcnt));

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drv_a(input logic [15:0] d, input logic [1:0] k);
    @(negedge clk);
    a_data = d;
    a_k    = k;
    if (a_expect && (k == 2'b00)) sb_q.push_back(d);
  endtask

  task automatic drv_b(input logic [31:0] d, input logic [3:0] k);
    @(negedge clk);
    b_data = d;
    b_k    = k;
  endtask

  task automatic bump_rcnt();
`ifdef SERDES_RX_REALIGN_CNT_EN
    exp_rcnt++;
`endif
  endtask

  // Bring DUT A from HUNT to LINKED at offset 0; the word before must be non-comma.
  task automatic link_a();
    a_expect = 1'b0;
    drv_a(CMA, 2'b01);
    drv_a(CMA, 2'b01);
    drv_a(RX_SYNC[63:48], 2'b00); check_eq("lock_wait", a_state, 0);
    drv_a(RX_SYNC[47:32], 2'b00); check_eq("locked", a_state, 1);
    bump_rcnt();
    check_eq("realign_cnt", a_rcnt, exp_rcnt);
    drv_a(RX_SYNC[31:16], 2'b00);
    drv_a(RX_SYNC[15:0], 2'b00);
    drv_a(CMA, 2'b01);
    drv_a(CMA, 2'b01);
    drv_a(CMA, 2'b01); check_eq("pre_link", a_state, 1);
    drv_a(CMA, 2'b01); check_eq("linked", a_state, 2);
    check_eq("rx_link", a_rx, 1);
  endtask

  // Scoreboard: every valid output word must match the oldest expected word.
  always @(negedge clk) begin
    if (a_ena) begin
      if (sb_q.size() == 0) check_eq("sb_unexpected_ena", a_ena, 0);
      else                  check_eq("sb_data", a_user, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_user", a_user, 0);
    check_eq("rst_ena", a_ena, 0);
    check_eq("rst_state", a_state, 0);
    check_eq("rst_tx", a_tx, 0);
    check_eq("rst_cfg", a_cfg, 0);
    rst_n = 1'b1;

    // 4-byte lanes, comma in byte 3, sync split across input words.
    drv_b(32'hbc00_0000, 4'b1000);
    drv_b(32'hbc00_0000, 4'b1000);
    drv_b({RX_SYNC[39:32], 24'h0}, 4'b0000);
    drv_b({RX_SYNC[7:0], RX_SYNC[63:40]}, 4'b0000); check_eq("b_locked", b_state, 1);
    drv_b({8'hbc, RX_SYNC[31:8]}, 4'b1000);
    drv_b(32'hbc00_0000, 4'b1000);
    drv_b(32'hbc00_0000, 4'b1000); check_eq("b_pre_link", b_state, 1);
    drv_b(32'hbc00_0000, 4'b1000); check_eq("b_linked", b_state, 2);
    check_eq("b_rx_link", b_rx, 1);

    link_a();

    // Three-cycle latency of a data word.
    a_expect = 1'b1;
    drv_a(16'h1234, 2'b00);
    drv_a(CMA, 2'b01);
    drv_a(CMA, 2'b01);
    drv_a(CMA, 2'b01);
    check_eq("lat_data", a_user, 16'h1234);
    check_eq("lat_ena", a_ena, 1);

    // Config header, a skipped K word, then the config word.
    drv_a(TX_SYNC[63:48], 2'b00);
    drv_a(TX_SYNC[47:32], 2'b00);
    drv_a(TX_SYNC[31:16], 2'b00);
    drv_a(TX_SYNC[15:0], 2'b00);
    drv_a(CMA, 2'b01);
    drv_a(16'ha55a, 2'b00);
    drv_a(CMA, 2'b01);
    drv_a(CMA, 2'b01); check_eq("tx_link", a_tx, 1);
    check_eq("cfg_early", a_cfg_ena, 0);
    drv_a(CMA, 2'b01); check_eq("cfg_pulse", a_cfg_ena, 1);
    check_eq("cfg_data", a_cfg, 16'ha55a);
    drv_a(CMA, 2'b01); check_eq("cfg_single", a_cfg_ena, 0);
    check_eq("cfg_hold", a_cfg, 16'ha55a);

    // Commas stop: loss after the timeout.
    drv_a(CMA, 2'b01);
    for (int i = 0; i < LOSS_T + 1; i++) drv_a(FILL, 2'b11);
    check_eq("loss_not_yet", a_state, 2);
    drv_a(FILL, 2'b11); check_eq("loss_hunt", a_state, 0);
    check_eq("loss_tx", a_tx, 0);
    check_eq("loss_rx", a_rx, 0);

    link_a();

    // Single comma at another offset while linked.
    a_expect = 1'b0;
    drv_a(16'hbc00, 2'b10); check_eq("mis_hold", a_state, 2);
    drv_a(FILL, 2'b11);     check_eq("mis_hold2", a_state, 2);
    drv_a(FILL, 2'b11);     check_eq("mis_hunt", a_state, 0);

    link_a();
    a_expect = 1'b1;
    drv_a(16'h5aa5, 2'b00);
    drv_a(CMA, 2'b01);
    drv_a(CMA, 2'b01);
    drv_a(CMA, 2'b01);
    a_expect = 1'b0;

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_user", a_user, 0);
    check_eq("arst_state", a_state, 0);
    check_eq("arst_rx", a_rx, 0);
    check_eq("arst_tx", a_tx, 0);
    check_eq("arst_cfg", a_cfg, 0);
    check_eq("arst_rcnt", a_rcnt, 0);
    check_eq("arst_b_state", b_state, 0);
    exp_rcnt = 0;
    a_data = FILL;
    a_k    = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;

    // Relock at offset 1; bytes 34,12 across words come out as 16'h1234.
    drv_a(16'hbc00, 2'b10);
    drv_a(16'hbc00, 2'b10);
    drv_a(16'h3400, 2'b00); check_eq("relock_wait", a_state, 0);
    drv_a(16'h0012, 2'b00); check_eq("relock_off1", a_state, 1);
    bump_rcnt();
    check_eq("relock_rcnt", a_rcnt, exp_rcnt);
    drv_a(16'hbc00, 2'b10);
    drv_a(16'hbc00, 2'b10); check_eq("off1_data", a_user, 16'h1234);
    check_eq("off1_no_ena", a_ena, 0);

    repeat (4) @(negedge clk);
    check_eq("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serdes_rx_link_align.md
# serdes_rx_link_align

Parametrised receive-side link front end for the 8b/10b SERDES user-data path. It sits between the transceiver RX parallel interface (decoded bytes plus per-byte K flags) and user logic. The block performs:
- comma alignment at any byte lane, with lock hysteresis;
- link bring-up on the 64-bit RX sync pattern;
- config-word capture after the 64-bit TX sync pattern;
- link-loss detection and automatic re-hunt when commas stop.

It generalises the team's fixed 2-byte interface to 2 or 4 bytes per word.

## Interface
- BYTES, 2, bytes per SERDES word (legal: 2, 4); W = 8*BYTES
- COMMA, 8'hBC, K-character used for alignment
- LOCK_CNT, 2, consecutive commas at one offset required to lock (1..15)
- LOSS_TIMEOUT, 1024, cycles without a locked-offset comma before link loss (2..65535)
- P_RX_SYNC, 64'hf1ba_84ff_aacd_f355, link-up pattern
- P_TX_SYNC, 64'hf1ba_84ff_aacd_2420, config-header pattern
- I_serdes_clk  in  1  RX user clock; single clock domain
- I_rst_n  in  1  asynchronous active-low reset
- I_serdes_data  in  W  decoded RX data; byte i = bits [8i+7:8i]
- I_data_is_k  in  BYTES  per-byte K flag
- O_user_data  out  W  aligned data word
- O_data_ena  out  1  O_user_data valid
- O_config_data  out  W  captured config word (held)
- O_config_ena  out  1  one-cycle pulse on config capture
- O_link_state  out  2  0=HUNT, 1=ALIGNED, 2=LINKED
- O_rx_link  out  1  O_link_state==LINKED
- O_tx_link  out  1  P_TX_SYNC seen since last HUNT
- O_realign_cnt  out  16  realignment counter (see Configuration)

Reset: one clock, asynchronous active-low reset (I_serdes_clk, I_rst_n). All registers and all outputs reset to 0; O_link_state resets to HUNT.

## Operation

Input pipeline and alignment:
- Stage 1 registers the input into R_data and R_k. Stage 2 holds the previous stage-1 word in R1_data and R1_k.
- Comma hit: the lowest byte index i for which R_k[i]=1 and that byte equals COMMA. This index is the candidate offset.
- Aligned word = low W bits of {R_data, R1_data} >> 8*offset. The aligned K vector is derived the same way from {R_k, R1_k}. With BYTES=2 and offset 1, the aligned word is {R_data[7:0], R1_data[15:8]}.

Sync shift register:
- 64-bit register. When aligned K is all zero, it shifts in the aligned word (left, W bits). K words do not shift.

State machine:
- HUNT: track the candidate offset and count consecutive hits at that offset. A hit at a different offset restarts the count at 1 with the new offset. When the count reaches LOCK_CNT: load the offset, go to ALIGNED, and increment O_realign_cnt.
- ALIGNED: when the shift register equals P_RX_SYNC, go to LINKED.
- ALIGNED or LINKED:
  - A comma hit at a different offset forces HUNT.
  - The loss timer clears on every comma hit at the locked offset and otherwise increments. When it reaches LOSS_TIMEOUT, go to HUNT.
- Entering HUNT clears O_tx_link, the shift register and the loss timer.

Config capture:
- Allowed in ALIGNED and LINKED only.
- When the shift register equals P_TX_SYNC: set O_tx_link and arm a capture flag.
- The next non-K aligned word is loaded into O_config_data, O_config_ena pulses for one cycle, and the flag clears.
- K words between the header and the config word are skipped.
- A new P_TX_SYNC match while the flag is armed re-arms it; only one capture occurs.

Data output:
- O_data_ena = LINKED and aligned K all zero. O_user_data updates every cycle.

## Timing
- Latency: a word whose last byte enters at cycle n appears on O_user_data at n+3, with O_data_ena valid in the same cycle.
- A comma presented at cycle n is evaluated at n+1. State and offset change at n+2.
- O_rx_link rises one cycle after the shift-register P_RX_SYNC match.
- O_config_ena and O_config_data update together one cycle after the config word is aligned.
- Simultaneous events: loss timeout and a misaligned comma in the same cycle give a single HUNT entry. A P_RX_SYNC match in the same cycle as a HUNT condition is ignored; HUNT wins.
- The loss timer saturates at LOSS_TIMEOUT and never wraps.
- Reset mid-operation: immediate return to reset values. O_config_data is cleared.

## Configuration
- SERDES_RX_REALIGN_CNT_EN defined: O_realign_cnt is a 16-bit counter that increments on each HUNT→ALIGNED lock, saturates at 16'hFFFF, and clears only on reset.
- SERDES_RX_REALIGN_CNT_EN undefined: O_realign_cnt is tied to 0 and the counter logic is absent. All other behaviour is identical.

## Test plan
- BYTES=2: commas 16'hc5bc (K=2'b01), then P_RX_SYNC as four words, then data 16'h1234 → O_link_state 0→1 after 2 commas, then 2. O_user_data=16'h1234 with O_data_ena=1 three cycles after input.
- BYTES=2, stream shifted by one byte (comma in high byte, K=2'b10) → offset 1 locks. Data bytes 34,12 across words appear as 16'h1234 aligned.
- BYTES=4, comma at byte 3 → lock at offset 3. P_RX_SYNC as two 32-bit words → LINKED.
- While LINKED: P_TX_SYNC, one comma word, then 16'hA55A → single O_config_ena pulse, O_config_data=16'hA55A, O_tx_link=1.
- While LINKED: stop commas for LOSS_TIMEOUT cycles → HUNT and O_tx_link=0. A single comma at a new offset while LINKED also gives HUNT. With the macro defined, O_realign_cnt=2 after relock.
- Assert I_rst_n low mid-stream → all outputs 0 asynchronously. After release, relock requires LOCK_CNT commas again.
